// File: rtl/pal_cfg_loader.sv
// PAL configuration chain loader: byte stream in, LSB-first serial data/clock out.
// Optional `PAL_CFG_CRC_EN adds a trailing CRC-8 byte check and the crc_err output.
module pal_cfg_loader #(
    parameter int NUM_INPUTS        = 8,
    parameter int NUM_OUTPUTS       = 8,
    parameter int NUM_INTERM_STAGES = 8,
    parameter int CLK_DIV           = 1,
    localparam int BITSTREAM_LEN    = 2 * NUM_INPUTS * NUM_INTERM_STAGES
                                      + NUM_INTERM_STAGES * NUM_OUTPUTS,
    localparam int CNT_W            = $clog2(BITSTREAM_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             cfg_data,
    output logic             cfg_clk,
    output logic             busy,
    output logic             done,
`ifdef PAL_CFG_CRC_EN
    output logic             crc_err,
`endif
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int PH_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_PULSE,
        S_FINISH,
        S_CHECK
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [3:0]        left_q, left_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              cfg_clk_q, cfg_clk_d;
    logic              cfg_data_q, cfg_data_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              handshake;
    logic              last_phase;
    logic [CNT_W-1:0]  remain;
`ifdef PAL_CFG_CRC_EN
    logic [7:0]        crc_q, crc_d;
    logic              crc_err_q, crc_err_d;
    logic              crc_fb;
`endif

    assign handshake  = in_valid && in_ready_q;
    assign last_phase = (phase_q == PH_W'(CLK_DIV - 1));
    assign remain     = CNT_W'(BITSTREAM_LEN) - bit_cnt_q;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        shreg_d    = shreg_q;
        left_d     = left_q;
        bit_cnt_d  = bit_cnt_q;
        cfg_data_d = cfg_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
`ifdef PAL_CFG_CRC_EN
        crc_d      = crc_q;
        crc_err_d  = crc_err_q;
        crc_fb     = crc_q[7] ^ shreg_q[0];
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d   = S_FETCH;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    bit_cnt_d = '0;
`ifdef PAL_CFG_CRC_EN
                    crc_d     = 8'h00;
                    crc_err_d = 1'b0;
`endif
                end
            end
            S_FETCH: begin
                if (handshake) begin
                    shreg_d    = in_data;
                    // A short final byte only carries the bits the chain still needs.
                    left_d     = (remain >= CNT_W'(8)) ? 4'd8 : 4'(remain);
                    cfg_data_d = in_data[0];
                    phase_d    = '0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (last_phase) begin
                    phase_d = '0;
                    state_d = S_PULSE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_PULSE: begin
                if (last_phase) begin
                    phase_d   = '0;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    left_d    = left_q - 4'd1;
`ifdef PAL_CFG_CRC_EN
                    crc_d     = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif
                    if (bit_cnt_d == CNT_W'(BITSTREAM_LEN)) begin
                        cfg_data_d = 1'b0;
`ifdef PAL_CFG_CRC_EN
                        state_d    = S_CHECK;
`else
                        state_d    = S_FINISH;
`endif
                    end else if (left_d == 4'd0) begin
                        state_d = S_FETCH;
                    end else begin
                        cfg_data_d = shreg_q[1];
                        state_d    = S_SETUP;
                    end
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_FINISH: begin
                cfg_data_d = 1'b0;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                state_d    = S_IDLE;
            end
`ifdef PAL_CFG_CRC_EN
            S_CHECK: begin
                if (handshake) begin
                    busy_d    = 1'b0;
                    done_d    = (in_data == crc_q);
                    crc_err_d = (in_data != crc_q);
                    state_d   = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, but leaves bit_cnt where it was for debug.
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            phase_d    = '0;
            bit_cnt_d  = bit_cnt_q;
            cfg_data_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end

        cfg_clk_d  = (state_d == S_PULSE);
        in_ready_d = (state_d == S_FETCH) || (state_d == S_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            shreg_q    <= '0;
            left_q     <= '0;
            bit_cnt_q  <= '0;
            cfg_clk_q  <= 1'b0;
            cfg_data_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PAL_CFG_CRC_EN
            crc_q      <= 8'h00;
            crc_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            left_q     <= left_d;
            bit_cnt_q  <= bit_cnt_d;
            cfg_clk_q  <= cfg_clk_d;
            cfg_data_q <= cfg_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef PAL_CFG_CRC_EN
            crc_q      <= crc_d;
            crc_err_q  <= crc_err_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign cfg_data = cfg_data_q;
    assign cfg_clk  = cfg_clk_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign bit_cnt  = bit_cnt_q;
`ifdef PAL_CFG_CRC_EN
    assign crc_err  = crc_err_q;
`endif

endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
- Sequences programming of the PAL configuration shift chain (AND-plane plus OR-plane bits).
- Accepts a bitstream as bytes over a valid/ready stream and serialises it onto the chain's config data/clock pair, LSB of byte 0 first.
- Generates a clean config clock and flags completion so top-level logic can release the PAL outputs.
- Sits between the host-facing IO wrapper and the PAL core.

Parameters:
- NUM_INPUTS, 8, PAL input count
- NUM_OUTPUTS, 8, PAL output count
- NUM_INTERM_STAGES, 8, product-term count
- CLK_DIV, 1, system cycles per config-clock phase (low phase and high phase each last CLK_DIV cycles); range 1..255
- BITSTREAM_LEN (localparam), 2*NUM_INPUTS*NUM_INTERM_STAGES + NUM_INTERM_STAGES*NUM_OUTPUTS (192 at defaults), chain length in bits

Ports:
- clk  in  1  system clock; the only clock in the block
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a programming session
- abort  in  1  synchronous abort of the current session
- in_data  in  8  bitstream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- cfg_data  out  1  serial config bit to the PAL chain
- cfg_clk  out  1  config shift clock to the PAL chain (chain shifts on rising edge)
- busy  out  1  session in progress
- done  out  1  chain fully programmed; sticky
- bit_cnt  out  $clog2(BITSTREAM_LEN+1)  bits shifted so far in this session

Behaviour:
- Reset (async, rst=1): state IDLE; cfg_clk=0, cfg_data=0, in_ready=0, busy=0, done=0, bit_cnt=0, phase counter=0.
- States: IDLE, FETCH, SETUP, PULSE, FINISH.
- IDLE:
  - start=1 -> FETCH, busy=1, done=0, bit_cnt=0.
  - start is ignored in every other state.
- FETCH:
  - in_ready=1.
  - in_valid&&in_ready latches the byte into the shift register -> SETUP.
  - in_ready is low in all other states; in_data is never sampled without the handshake.
- SETUP:
  - cfg_data = shreg[0]; cfg_clk=0 for CLK_DIV cycles -> PULSE.
- PULSE:
  - cfg_clk=1 for CLK_DIV cycles; cfg_data held stable.
  - On the last PULSE cycle: bit_cnt+=1 and the byte is shifted right.
  - Then:
    - bit_cnt==BITSTREAM_LEN -> FINISH;
    - 8 bits consumed from the current byte -> FETCH;
    - otherwise -> SETUP.
- Partial final byte (BITSTREAM_LEN not a multiple of 8): only the remaining low bits are shifted; the upper bits are discarded.
- FINISH:
  - cfg_clk=0, cfg_data=0 -> IDLE with done=1, busy=0.
  - done stays 1 until the next start or reset.
- Timing: each bit takes 2*CLK_DIV cycles. cfg_data changes only in SETUP, at least CLK_DIV cycles before the cfg_clk rise, and never while cfg_clk=1.
- All outputs are registered, so cfg_clk is glitch-free.
- Stall: if in_valid stays low in FETCH, the loader waits indefinitely with cfg_clk=0.
- abort=1 in any non-IDLE state -> IDLE next cycle: cfg_clk=0, busy=0, done=0; bit_cnt holds its value for debug. abort in IDLE has no effect.
- abort and start in the same cycle: abort wins.
- Reset mid-session: immediate return to reset values. The chain is left partially loaded; a new session must be started.

Optional Feature:
- Macro: PAL_CFG_CRC_EN.
- When defined:
  - A CRC-8 (poly 0x07, init 0x00) is updated on each shifted bit, LSB-first and bit-serial.
  - After the last chain bit, FINISH is replaced by a CHECK state: one extra byte is accepted via FETCH handshake and compared with the CRC.
  - Match -> done=1. Mismatch -> done=0 plus output crc_err=1 (sticky until start/rst).
  - Extra port crc_err (out, 1).
- When undefined: no CHECK state, no crc_err port, done is set directly after the last bit.

Test Plan:
- Defaults, CLK_DIV=1, start plus 24 bytes with in_valid always high:
  - exactly 192 cfg_clk rising edges;
  - bit k on cfg_data equals byte[k/8] bit (k%8) at each rise;
  - done=1 after a total of 384+24+2 cycles ±1.
- Back-pressure: in_valid deasserted for 10 cycles before byte 5 -> cfg_clk stays 0 during the gap; final bitstream still correct; bit_cnt=40 throughout the gap.
- CLK_DIV=3: cfg_clk low 3 cycles / high 3 cycles per bit; cfg_data never toggles while cfg_clk=1.
- Abort after 100 bits -> next cycle busy=0, cfg_clk=0, done=0, bit_cnt=100. A new start then completes with done=1 and bit_cnt=192.
- Async rst asserted mid-PULSE -> cfg_clk=0 immediately (before the next clk edge); all outputs at reset values.
- PAL_CFG_CRC_EN:
  - correct CRC byte -> done=1, crc_err=0;
  - CRC byte XOR 0x01 -> done=0, crc_err=1.
